// File: rtl/sme_stim_driver_pkg.sv
// Shared types and constants for the SME stimulus driver: FSM states,
// bus widths, grading weights and the length clamp helper.
package sme_pkg;

    localparam int CHAR_W = 8;
    localparam int IDX_W  = 5;

    localparam logic [1:0] SC_MATCH = 2'd1;
    localparam logic [1:0] SC_INDEX = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        SEND_STR,
        SEND_PAT,
        WAIT,
        GRADE
    } state_t;

    // A zero length still sends one char; anything past the buffer depth is capped.
    function automatic logic [5:0] clamp_len(input logic [5:0] len, input logic [5:0] max_len);
        if (len == 6'd0)
            return 6'd1;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage

// File: rtl/sme_stim_driver_if.sv
// Character/result bus between the stimulus driver (master) and the
// string-match engine (slave).
interface sme_stim_driver_if;
    import sme_pkg::*;

    logic [CHAR_W-1:0] chardata;
    logic              isstring;
    logic              ispattern;
    logic              valid;
    logic              match;
    logic [IDX_W-1:0]  match_index;

    modport master (
        output chardata, isstring, ispattern,
        input  valid, match, match_index
    );

    modport slave (
        input  chardata, isstring, ispattern,
        output valid, match, match_index
    );

endinterface

// File: rtl/sme_stim_driver_char_buf.sv
// Single-write, single-read character register file; contents survive reset
// so a loaded string can be replayed across jobs.
module sme_char_buf
    import sme_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [CHAR_W-1:0] rd_data
);

    logic [CHAR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sme_stim_driver.sv
// Streams a buffered string and pattern into the SME, waits for its result
// and grades it against the expected outcome, keeping a saturating score.
module sme_stim_driver
    import sme_pkg::*;
#(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic                wr_sel,
    input  logic [4:0]          wr_addr,
    input  logic [CHAR_W-1:0]   wr_data,
    input  logic [5:0]          str_len,
    input  logic [3:0]          pat_len,
    input  logic                send_str,
    input  logic                exp_match,
    input  logic [IDX_W-1:0]    exp_index,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                timeout,
    output logic [15:0]         score,
    sme_stim_driver_if.master   sme
);

    localparam int STR_AW = $clog2(STR_MAX);
    localparam int PAT_AW = $clog2(PAT_MAX);
    localparam int WAIT_W = $clog2(TIMEOUT) + 1;

    state_t             state;
    logic [5:0]         cnt;
    logic [5:0]         slen;
    logic [5:0]         plen;
    logic [WAIT_W-1:0]  wcnt;
    logic               exp_match_q;
    logic [IDX_W-1:0]   exp_index_q;
    logic               got_match;
    logic [IDX_W-1:0]   got_index;
    logic               hit_timeout;
    logic [CHAR_W-1:0]  chardata_q;
    logic               isstring_q;
    logic               ispattern_q;

    logic [STR_AW-1:0]  str_rd_addr;
    logic [PAT_AW-1:0]  pat_rd_addr;
    logic [CHAR_W-1:0]  str_rd_data;
    logic [CHAR_W-1:0]  pat_rd_data;

    logic [1:0]         inc;
    logic               grade_ok;
    logic [16:0]        score_sum;

    // The counter always points at the next char to emit; outside its own
    // sending phase each buffer is parked on index 0 for the first char.
    assign str_rd_addr = (state == SEND_STR) ? cnt[STR_AW-1:0] : '0;
    assign pat_rd_addr = (state == SEND_PAT) ? cnt[PAT_AW-1:0] : '0;

    sme_char_buf #(.DEPTH(STR_MAX)) u_str_buf (
        .clk     (clk),
        .wr_en   (wr_en && !wr_sel),
        .wr_addr (wr_addr[STR_AW-1:0]),
        .wr_data (wr_data),
        .rd_addr (str_rd_addr),
        .rd_data (str_rd_data)
    );

    sme_char_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
        .clk     (clk),
        .wr_en   (wr_en && wr_sel),
        .wr_addr (wr_addr[PAT_AW-1:0]),
        .wr_data (wr_data),
        .rd_addr (pat_rd_addr),
        .rd_data (pat_rd_data)
    );

    always_comb begin
        inc      = 2'd0;
        grade_ok = 1'b0;
        if (!hit_timeout) begin
            if (exp_match_q) begin
                if (got_match) begin
                    inc = SC_MATCH;
                    if (got_index == exp_index_q) begin
                        inc      = SC_MATCH + SC_INDEX;
                        grade_ok = 1'b1;
                    end
                end
            end else if (!got_match) begin
                inc      = SC_MATCH;
                grade_ok = 1'b1;
            end
        end
    end

    assign score_sum = {1'b0, score} + {15'd0, inc};

    assign sme.chardata  = chardata_q;
    assign sme.isstring  = isstring_q;
    assign sme.ispattern = ispattern_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            slen        <= '0;
            plen        <= '0;
            wcnt        <= '0;
            exp_match_q <= 1'b0;
            exp_index_q <= '0;
            got_match   <= 1'b0;
            got_index   <= '0;
            hit_timeout <= 1'b0;
            chardata_q  <= '0;
            isstring_q  <= 1'b0;
            ispattern_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            score       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        pass        <= 1'b0;
                        timeout     <= 1'b0;
                        slen        <= clamp_len(str_len, 6'(STR_MAX));
                        plen        <= clamp_len({2'b00, pat_len}, 6'(PAT_MAX));
                        exp_match_q <= exp_match;
                        exp_index_q <= exp_index;
                        cnt         <= 6'd1;
                        if (send_str) begin
                            state      <= SEND_STR;
                            isstring_q <= 1'b1;
                            chardata_q <= str_rd_data;
                        end else begin
                            state       <= SEND_PAT;
                            ispattern_q <= 1'b1;
                            chardata_q  <= pat_rd_data;
                        end
                    end
                end
                SEND_STR: begin
                    if (cnt == slen) begin
                        state       <= SEND_PAT;
                        isstring_q  <= 1'b0;
                        ispattern_q <= 1'b1;
                        chardata_q  <= pat_rd_data;
                        cnt         <= 6'd1;
                    end else begin
                        chardata_q <= str_rd_data;
                        cnt        <= cnt + 6'd1;
                    end
                end
                SEND_PAT: begin
                    if (cnt == plen) begin
                        state       <= WAIT;
                        ispattern_q <= 1'b0;
                        wcnt        <= '0;
                    end else begin
                        chardata_q <= pat_rd_data;
                        cnt        <= cnt + 6'd1;
                    end
                end
                WAIT: begin
                    if (sme.valid) begin
                        state       <= GRADE;
                        got_match   <= sme.match;
                        got_index   <= sme.match_index;
                        hit_timeout <= 1'b0;
                    end else if (wcnt == WAIT_W'(TIMEOUT - 1)) begin
                        state       <= GRADE;
                        hit_timeout <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                GRADE: begin
                    state   <= IDLE;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    pass    <= grade_ok;
                    timeout <= hit_timeout;
                    score   <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sme_stim_driver.sv
// Self-checking bench: directed jobs followed by random jobs, compared against
// a char-stream and grading model built from buffer contents and lengths.
module tb_sme_stim_driver;
    import sme_pkg::*;

    localparam int TIMEOUT = 4096;

    typedef struct packed {
        logic       s;
        logic       p;
        logic [7:0] c;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [5:0]  str_len = '0;
    logic [3:0]  pat_len = '0;
    logic        send_str = 1'b0;
    logic        exp_match = 1'b0;
    logic [4:0]  exp_index = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [15:0] score;

    logic [7:0]  str_model [32];
    logic [7:0]  pat_model [8];
    int          exp_score = 0;
    int          compared = 0;
    int          mismatched = 0;

    sme_stim_driver_if sme();

    sme_stim_driver #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .str_len   (str_len),
        .pat_len   (pat_len),
        .send_str  (send_str),
        .exp_match (exp_match),
        .exp_index (exp_index),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .timeout   (timeout),
        .score     (score),
        .sme       (sme)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic writeChar(input bit sel, input int addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 5'(addr);
        wr_data = data;
        if (sel) pat_model[addr % 8] = data;
        else     str_model[addr] = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic writeText(input bit sel, input string text);
        for (int i = 0; i < text.len(); i++)
            writeChar(sel, i, text[i]);
    endtask

    // Runs one job from IDLE and checks the char stream, timing and grade.
    task automatic applyStimulus(input bit snd, input logic [5:0] sl, input logic [3:0] pl,
                                 input bit em, input logic [4:0] ei, input bit respond,
                                 input bit rm, input logic [4:0] ri, input int delay,
                                 input bit disturb);
        beat_t exp_q[$];
        beat_t obs_q[$];
        int    es, ep, cyc, end_cyc, done_cyc, inc, n;
        bit    exp_pass, busy_ok, excl_ok, streamed, pulsed;

        es = (sl == 0) ? 1 : (sl > 32) ? 32 : int'(sl);
        ep = (pl == 0) ? 1 : (pl > 8) ? 8 : int'(pl);
        if (snd)
            for (int i = 0; i < es; i++) exp_q.push_back(beat_t'{1'b1, 1'b0, str_model[i]});
        for (int i = 0; i < ep; i++) exp_q.push_back(beat_t'{1'b0, 1'b1, pat_model[i]});

        inc = 0;
        exp_pass = 1'b0;
        if (respond) begin
            if (em) begin
                if (rm) inc = (ri == ei) ? 3 : 1;
                exp_pass = rm && (ri == ei);
            end else if (!rm) begin
                inc = 1;
                exp_pass = 1'b1;
            end
        end

        send_str  = snd;
        str_len   = sl;
        pat_len   = pl;
        exp_match = em;
        exp_index = ei;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        str_len   = 6'($urandom);
        pat_len   = 4'($urandom);
        exp_match = ~em;
        exp_index = 5'($urandom);
        send_str  = ~snd;

        cyc = 0; end_cyc = -1; done_cyc = -1;
        busy_ok = 1'b1; excl_ok = 1'b1; streamed = 1'b0; pulsed = 1'b0;
        while (done_cyc < 0 && cyc < es + ep + TIMEOUT + 20) begin
            sme.valid = 1'b0;
            start = 1'b0;
            if (sme.isstring && sme.ispattern) excl_ok = 1'b0;
            if (sme.isstring || sme.ispattern) begin
                obs_q.push_back(beat_t'{sme.isstring, sme.ispattern, sme.chardata});
                streamed = 1'b1;
            end else if (streamed && end_cyc < 0) begin
                end_cyc = cyc;
            end
            if (done) done_cyc = cyc;
            else if (!busy) busy_ok = 1'b0;
            if (disturb && sme.isstring && cyc < 2) start = 1'b1;
            if (disturb && sme.ispattern && !pulsed) begin
                sme.valid = 1'b1;
                sme.match = ~rm;
                sme.match_index = ~ri;
                pulsed = 1'b1;
            end
            if (respond && end_cyc >= 0 && cyc == end_cyc + delay) begin
                sme.valid = 1'b1;
                sme.match = rm;
                sme.match_index = ri;
            end
            if (done_cyc < 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        sme.valid = 1'b0;
        start = 1'b0;

        if (done_cyc < 0) begin
            checkOutput("done_seen", 32'd0, 32'd1);
            return;
        end
        exp_score = (exp_score + inc > 65535) ? 65535 : exp_score + inc;

        checkOutput("stream_len", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            checkOutput("stream_beat", 32'(obs_q[i]), 32'(exp_q[i]));
        checkOutput("exclusive", excl_ok, 1);
        checkOutput("busy_held", busy_ok, 1);
        checkOutput("done_latency", done_cyc - end_cyc, respond ? delay + 2 : TIMEOUT + 1);
        checkOutput("busy_at_done", busy, 0);
        checkOutput("pass", pass, exp_pass);
        checkOutput("timeout", timeout, !respond);
        checkOutput("score", score, exp_score);
        @(negedge clk);
        checkOutput("done_pulse", done, 0);
        checkOutput("pass_hold", pass, exp_pass);
    endtask

    initial begin
        sme.valid = 1'b0;
        sme.match = 1'b0;
        sme.match_index = '0;
        #3 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pass", pass, 0);
        checkOutput("rst_timeout", timeout, 0);
        checkOutput("rst_score", score, 0);
        checkOutput("rst_chardata", sme.chardata, 0);
        checkOutput("rst_flags", {sme.isstring, sme.ispattern}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] job 1: string abcabc, pattern ca, full match");
        writeText(1'b0, "abcabc");
        writeText(1'b1, "ca");
        applyStimulus(1, 6, 2, 1, 2, 1, 1, 2, 3, 0);
        checkOutput("job1_score", score, 3);

        $display("[TB] job 2: pattern only zz, no match expected");
        writeText(1'b1, "zz");
        applyStimulus(0, 6, 2, 0, 0, 1, 0, 7, 0, 0);

        $display("[TB] job 3: wrong index");
        applyStimulus(1, 6, 2, 1, 4, 1, 1, 5, 1, 0);

        $display("[TB] job 4: SME silent, timeout");
        applyStimulus(1, 6, 2, 1, 2, 0, 0, 0, 0, 0);

        $display("[TB] job 5: stray start and early valid");
        applyStimulus(1, 6, 2, 1, 2, 1, 1, 2, 2, 1);

        $display("[TB] job 6: reset during pattern phase");
        writeText(1'b1, "pattern!");
        send_str = 1'b1; str_len = 6'd4; pat_len = 4'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 50 && !sme.ispattern; k++) @(negedge clk);
        checkOutput("reach_pattern", sme.ispattern, 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("mid_rst_flags", {sme.isstring, sme.ispattern}, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_score", score, 0);
        exp_score = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(1, 6, 2, 1, 0, 1, 1, 0, 4, 0);

        $display("[TB] clamp edges");
        for (int i = 0; i < 32; i++) writeChar(1'b0, i, 8'($urandom_range(32, 126)));
        for (int i = 0; i < 8; i++)  writeChar(1'b1, i, 8'($urandom_range(32, 126)));
        applyStimulus(1, 0, 15, 0, 0, 1, 1, 3, 0, 0);
        applyStimulus(1, 40, 0, 1, 9, 1, 1, 9, 5, 0);

        $display("[TB] random jobs");
        for (int j = 0; j < 12; j++) begin
            logic [4:0] ei;
            logic [4:0] ri;
            for (int w = 0; w < 4; w++) begin
                bit sel;
                sel = 1'($urandom);
                writeChar(sel, sel ? $urandom_range(0, 7) : $urandom_range(0, 31),
                          8'($urandom_range(32, 126)));
            end
            ei = 5'($urandom);
            ri = $urandom_range(0, 1) ? ei : 5'($urandom);
            applyStimulus(1'($urandom), 6'($urandom_range(0, 40)), 4'($urandom_range(0, 10)),
                          1'($urandom), ei, 1, 1'($urandom), ri, $urandom_range(0, 20), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
